// File: rtl/aes_tcdm_responder.sv
// rtl/aes_tcdm_responder.sv - single-bank TCDM responder with round-robin arbitration and periodic grant stalls
module aes_tcdm_responder #(
  parameter int unsigned MP           = 2,
  parameter int unsigned DEPTH        = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned STALL_PERIOD = 4,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  input  logic                 stall_en_i,
  output logic                 err_o,
  output logic [31:0]          access_cnt_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned SW        = $clog2(STALL_PERIOD);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [PW-1:0] LAST_PORT = PW'(MP - 1);
  localparam logic [SW-1:0] LAST_SCNT = SW'(STALL_PERIOD - 1);

  logic [31:0]         mem_q [DEPTH];
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [MP-1:0]       r_valid_q, r_valid_d;
  logic [MP-1:0][31:0] r_data_q, r_data_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;

  logic                stall;
  logic                gnt_any;
  logic [PW-1:0]       win;
  logic [31:0]         off;
  logic                in_range;
  logic [AW-1:0]       idx;

  // Round-robin scan starting at rr_ptr; the stall slot blocks every port
  always_comb begin
    logic [PW-1:0] p;
    p          = rr_ptr_q;
    tcdm_gnt_o = '0;
    gnt_any    = 1'b0;
    win        = '0;
    stall      = stall_en_i && (scnt_q == LAST_SCNT);
    for (int unsigned i = 0; i < MP; i++) begin
      if (!stall && !gnt_any && tcdm_req_i[p]) begin
        gnt_any = 1'b1;
        win     = p;
      end
      p = (p == LAST_PORT) ? '0 : p + PW'(1);
    end
    if (gnt_any) tcdm_gnt_o[win] = 1'b1;
  end

  // Address decode of the winning port; below-base addresses wrap to huge offsets and fall out of range
  assign off      = tcdm_add_i[win] - BASE_ADDR;
  assign in_range = off < MEM_BYTES;
  assign idx      = off[2 +: AW];

  // Next-state for pointer, stall counter, response pipeline, error flag and access counter
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    scnt_d    = (scnt_q == LAST_SCNT) ? '0 : scnt_q + SW'(1);
    r_valid_d = '0;
    r_data_d  = r_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (gnt_any) begin
      rr_ptr_d = (win == LAST_PORT) ? '0 : win + PW'(1);
      cnt_d    = cnt_q + 32'd1;
      if (!in_range) err_d = 1'b1;
      if (tcdm_wen_i[win]) begin
        r_valid_d[win] = 1'b1;
        r_data_d[win]  = in_range ? mem_q[idx] : ERR_DATA;
      end
    end
  end

  // Control and response registers; reset discards any grant of the reset cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      scnt_q    <= '0;
      r_valid_q <= '0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      scnt_q    <= scnt_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Byte-masked write port of the storage array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && gnt_any && in_range && !tcdm_wen_i[win]) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm_be_i[win][b]) mem_q[idx][8*b +: 8] <= tcdm_data_i[win][8*b +: 8];
      end
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign err_o          = err_q;
  assign access_cnt_o   = cnt_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// tb/tb_aes_tcdm_responder.sv - table-driven bench for aes_tcdm_responder
module tb_aes_tcdm_responder;

  localparam int MP = 2;
  localparam int NV = 18;

  logic                clk = 1'b0;
  logic                rst;
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] wdata;
  logic [MP-1:0][31:0] rdata;
  logic [MP-1:0]       rvalid;
  logic                stall_en;
  logic                err;
  logic [31:0]         cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_tcdm_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rvalid),
    .stall_en_i     (stall_en),
    .err_o          (err),
    .access_cnt_o   (cnt)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [31:0] a0, a1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1;
    logic [1:0]  g;
    logic [1:0]  rv;
    logic [31:0] r0, r1;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] rq, wn, input logic [31:0] a0, a1,
                              input logic [3:0] be0, be1, input logic [31:0] d0, d1,
                              input logic [1:0] g, rv, input logic [31:0] r0, r1, c,
                              input logic e);
    vec_t v;
    v.req = rq; v.wen = wn; v.a0 = a0; v.a1 = a1; v.be0 = be0; v.be1 = be1;
    v.d0 = d0; v.d1 = d1; v.g = g; v.rv = rv; v.r0 = r0; v.r1 = r1; v.cnt = c; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rq, wn, input logic [31:0] a0, a1,
                       input logic [3:0] be0, be1, input logic [31:0] d0, d1);
    req = rq; wen = wn;
    add[0] = a0; add[1] = a1;
    be[0] = be0; be[1] = be1;
    wdata[0] = d0; wdata[1] = d1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_rdata0"}, rdata[0], 32'h0);
    chk({tag, "_rdata1"}, rdata[1], 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_cnt"}, cnt, 32'h0);
  endtask

  initial begin
    int p0, p1, ng;
    logic exp_g;

    vecs[0]  = mk(2'b01, 2'b10, 32'h10,  32'h0, 4'hF, 4'hF, 32'h1234_5678, 32'h0,         2'b01, 2'b00, 32'h0,         32'h0,         32'd1,  1'b0);
    vecs[1]  = mk(2'b01, 2'b11, 32'h10,  32'h0, 4'hF, 4'hF, 32'h0,         32'h0,         2'b01, 2'b01, 32'h1234_5678, 32'h0,         32'd2,  1'b0);
    vecs[2]  = mk(2'b10, 2'b01, 32'h0,   32'h20, 4'hF, 4'hF, 32'h0,        32'hFFFF_FFFF, 2'b10, 2'b00, 32'h1234_5678, 32'h0,         32'd3,  1'b0);
    vecs[3]  = mk(2'b10, 2'b01, 32'h0,   32'h20, 4'hF, 4'h1, 32'h0,        32'h0000_00AA, 2'b10, 2'b00, 32'h1234_5678, 32'h0,         32'd4,  1'b0);
    vecs[4]  = mk(2'b10, 2'b11, 32'h0,   32'h20, 4'hF, 4'hF, 32'h0,        32'h0,         2'b10, 2'b10, 32'h1234_5678, 32'hFFFF_FFAA, 32'd5,  1'b0);
    vecs[5]  = mk(2'b01, 2'b10, 32'h24,  32'h0, 4'hF, 4'hF, 32'hA5A5_A5A5, 32'h0,         2'b01, 2'b00, 32'h1234_5678, 32'hFFFF_FFAA, 32'd6,  1'b0);
    vecs[6]  = mk(2'b01, 2'b10, 32'h24,  32'h0, 4'h0, 4'hF, 32'h0,         32'h0,         2'b01, 2'b00, 32'h1234_5678, 32'hFFFF_FFAA, 32'd7,  1'b0);
    vecs[7]  = mk(2'b01, 2'b11, 32'h24,  32'h0, 4'hF, 4'hF, 32'h0,         32'h0,         2'b01, 2'b01, 32'hA5A5_A5A5, 32'hFFFF_FFAA, 32'd8,  1'b0);
    vecs[8]  = mk(2'b10, 2'b11, 32'h0,   32'h20, 4'hF, 4'hF, 32'h0,        32'h0,         2'b10, 2'b10, 32'hA5A5_A5A5, 32'hFFFF_FFAA, 32'd9,  1'b0);
    for (int i = 0; i < 6; i++) begin
      vecs[9+i] = mk(2'b11, 2'b11, 32'h12, 32'h20, 4'hF, 4'hF, 32'h0, 32'h0,
                     (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b01 : 2'b10,
                     32'h1234_5678, 32'hFFFF_FFAA, 32'(10 + i), 1'b0);
    end
    vecs[15] = mk(2'b01, 2'b11, 32'h400, 32'h0, 4'hF, 4'hF, 32'h0,         32'h0,         2'b01, 2'b01, 32'hDEAD_BEEF, 32'hFFFF_FFAA, 32'd16, 1'b1);
    vecs[16] = mk(2'b00, 2'b11, 32'h0,   32'h0, 4'hF, 4'hF, 32'h0,         32'h0,         2'b00, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFAA, 32'd16, 1'b1);
    vecs[17] = mk(2'b10, 2'b01, 32'h0,   32'hFFFF_FFFC, 4'hF, 4'hF, 32'h0, 32'h0,         2'b10, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFAA, 32'd17, 1'b1);

    rst = 1'b1;
    stall_en = 1'b0;
    drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    tick;
    tick;
    chk_reset_state("init");
    rst = 1'b0;

    p0 = 0;
    p1 = 0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].wen, vecs[i].a0, vecs[i].a1, vecs[i].be0, vecs[i].be1, vecs[i].d0, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].g));
      tick;
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_rdata0", i), rdata[0], vecs[i].r0);
      chk($sformatf("v%0d_rdata1", i), rdata[1], vecs[i].r1);
      chk($sformatf("v%0d_cnt", i), cnt, vecs[i].cnt);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      if (i >= 9 && i <= 14) begin
        p0 += int'(rvalid[0]);
        p1 += int'(rvalid[1]);
      end
    end
    chk("rr_pulses_p0", 32'(p0), 32'd3);
    chk("rr_pulses_p1", 32'(p1), 32'd3);

    rst = 1'b1;
    drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    tick;
    chk_reset_state("rst2");
    rst = 1'b0;

    stall_en = 1'b1;
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 2'b11, 32'h10, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0);
      exp_g = (i % 4) != 3;
      #1;
      chk($sformatf("stall%0d_gnt", i), 32'(gnt), {31'h0, exp_g});
      tick;
      chk($sformatf("stall%0d_rvalid", i), 32'(rvalid), {31'h0, exp_g});
      if (exp_g) begin
        ng++;
        chk($sformatf("stall%0d_rdata0", i), rdata[0], 32'h1234_5678);
      end
    end
    chk("stall_cnt", cnt, 32'd6);
    chk("stall_grants", 32'(ng), 32'd6);
    stall_en = 1'b0;

    drive(2'b01, 2'b11, 32'h404, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0);
    tick;
    chk("oor2_err", 32'(err), 32'h1);
    drive(2'b01, 2'b11, 32'h20, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0);
    tick;
    chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    chk("pre_rst_rdata0", rdata[0], 32'hFFFF_FFAA);
    rst = 1'b1;
    drive(2'b01, 2'b10, 32'h10, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0);
    tick;
    chk_reset_state("rst3");
    rst = 1'b0;
    drive(2'b11, 2'b11, 32'h10, 32'h20, 4'hF, 4'hF, 32'h0, 32'h0);
    #1;
    chk("post_rst_gnt_a", 32'(gnt), 32'h1);
    tick;
    chk("post_rst_rvalid_a", 32'(rvalid), 32'h1);
    chk("post_rst_rdata0", rdata[0], 32'h1234_5678);
    chk("post_rst_cnt_a", cnt, 32'd1);
    drive(2'b10, 2'b11, 32'h10, 32'h20, 4'hF, 4'hF, 32'h0, 32'h0);
    #1;
    chk("post_rst_gnt_b", 32'(gnt), 32'h2);
    tick;
    chk("post_rst_rvalid_b", 32'(rvalid), 32'h2);
    chk("post_rst_rdata1", rdata[1], 32'hFFFF_FFAA);
    chk("post_rst_cnt_b", cnt, 32'd2);
    drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_tcdm_responder.md
Name: aes_tcdm_responder

Overview:
- TCDM slave (HWPE-Mem responder) that serves the MP TCDM master ports driven by the AES accelerator streamer.
- Single-bank word memory; one access per cycle; round-robin arbitration across ports.
- Optional periodic grant stalls to exercise streamer backpressure.
- Used as memory model in block-level simulation and as a scratch bank in small integrations.

Parameters:
- MP, 2, number of TCDM ports served.
- DEPTH, 256, memory depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned).
- STALL_PERIOD, 4, grant suppressed once every STALL_PERIOD cycles when stall_en_i=1 (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- tcdm_req_i  in  MP  per-port request
- tcdm_gnt_o  out  MP  per-port grant (combinational from req/state)
- tcdm_add_i  in  MPx32  per-port byte address
- tcdm_wen_i  in  MP  1=read, 0=write
- tcdm_be_i  in  MPx4  byte enables for writes
- tcdm_data_i  in  MPx32  write data
- tcdm_r_data_o  out  MPx32  read data
- tcdm_r_valid_o  out  MP  read data valid, one cycle after grant
- stall_en_i  in  1  enable periodic grant suppression
- err_o  out  1  sticky out-of-range flag
- access_cnt_o  out  32  count of granted transactions, wraps at 2^32

Behaviour:
- Reset (rst_i=1 at edge):
  - r_valid=0, r_data=0 on all ports.
  - err_o=0; access_cnt_o=0.
  - rr_ptr=0; stall counter=0.
  - Memory contents not reset.
  - A grant issued in the reset cycle is discarded: no response, no write.
- Arbitration:
  - At most one gnt bit high per cycle.
  - Winner is the first requesting port scanning rr_ptr, rr_ptr+1, ... mod MP.
  - On grant to port k, rr_ptr <= (k+1) mod MP; with no grant, rr_ptr holds.
- Stall:
  - Free-running counter scnt counts 0..STALL_PERIOD-1 and wraps.
  - When stall_en_i=1 and scnt==STALL_PERIOD-1, all gnt=0 and rr_ptr holds.
  - Requesters must hold req and signals until granted.
- Address decode:
  - off = add - BASE_ADDR; word index = off[2 +: log2(DEPTH)]; add[1:0] ignored.
  - In range iff off < DEPTH*4.
- Write (wen=0, granted):
  - Bytes with be[i]=1 updated at the clock edge; be=0 is a legal no-op.
  - No r_valid is generated for writes.
- Read (wen=1, granted in cycle t):
  - r_valid[k]=1 in cycle t+1 only, with r_data[k]=mem[idx] sampled at edge t.
  - Read and write to the same word in consecutive cycles: the read returns the newly written data.
  - r_data holds its last value when r_valid=0.
  - Other ports' r_valid stay 0.
- Out of range:
  - Still granted.
  - Write dropped; read returns ERR_DATA with r_valid.
  - err_o set the next cycle and held until reset.
- access_cnt_o increments by 1 per grant, including stall-free and out-of-range accesses.
- Back-to-back operation: one grant every cycle (absent stalls); response pipeline fully pipelined, no bubbles.

Test Plan:
- Reset, then port0 writes 32'h1234_5678 to BASE+0x10 with be=4'hF, then reads it back -> gnt same cycle as req; r_valid[0]=1 one cycle after read grant with r_data=32'h1234_5678; access_cnt_o=2.
- Partial write: word holds 32'hFFFF_FFFF; write 32'h0000_00AA with be=4'b0001; read -> 32'hFFFF_FFAA.
- Both ports request reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each port receives 3 r_valid pulses carrying the correct data.
- stall_en_i=1, STALL_PERIOD=4, port0 requests for 8 cycles -> gnt low on cycles where scnt=3 (2 of 8); request held until granted; access_cnt_o=6.
- Read at BASE+DEPTH*4 -> granted; r_valid with 32'hDEAD_BEEF; err_o=1 from next cycle and stays 1.
- Assert rst_i in the cycle after a read grant -> r_valid=0 that cycle; err_o=0, access_cnt_o=0, rr_ptr=0; memory retains data on subsequent read.
